// File: rtl/frame_sum_max_if.sv
// Stream bundle for frame_sum_max: operand input handshake plus held result output.
interface frame_sum_max_if #(
    parameter int WIDTH = 4,
    parameter int SUM_W = 7,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [WIDTH-1:0] out_max;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_cnt, out_ovf
    );

    // The accumulating block.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_cnt, out_ovf
    );
endinterface

// File: rtl/frame_sum_max.sv
// Streaming frame accumulator: sums, maxes and counts operands of one frame,
// then holds the result until the downstream takes it.
module frame_sum_max #(
    parameter int WIDTH = 4,
    parameter int COUNT = 8,
    parameter int SUM_W = 7,
    parameter int CNT_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            clear,
    frame_sum_max_if.slave bus
);
    localparam int EXT_W = SUM_W + 1;

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             live;
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] max_r;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             close;
    logic             release_res;
    logic [EXT_W-1:0] sum_ext;
    logic [CNT_W-1:0] cnt_nx;

    // Beat acceptance, widened sum with carry, and frame-close detection.
    always_comb begin
        accept      = bus.in_valid && bus.in_ready;
        sum_ext     = {1'b0, sum} + EXT_W'(bus.in_data);
        cnt_nx      = cnt + 1'b1;
        close       = accept && (bus.in_last || (cnt_nx == CNT_W'(COUNT)));
        release_res = (state == HOLD) && bus.out_ready;
    end

    // Next-state logic and handshake outputs; ready/valid depend on registers only.
    always_comb begin
        state_nx      = state;
        bus.in_ready  = live && (state == ACC);
        bus.out_valid = (state == HOLD);
        if (clear) begin
            state_nx = ACC;
        end else begin
            case (state)
                ACC:     if (close)       state_nx = HOLD;
                HOLD:    if (bus.out_ready) state_nx = ACC;
                default: state_nx = ACC;
            endcase
        end
    end

    // State register; live keeps in_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
        end
    end

    // Frame accumulators; cleared on abort or once the held result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            max_r <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear || release_res) begin
            sum   <= '0;
            max_r <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            sum <= sum_ext[SUM_W-1:0];
            ovf <= ovf | sum_ext[SUM_W];
            cnt <= cnt_nx;
            if ((cnt == '0) || (bus.in_data > max_r)) begin
                max_r <= bus.in_data;
            end
        end
    end

    // Result outputs come straight from the accumulators, which are frozen in HOLD.
    always_comb begin
        bus.out_sum = sum;
        bus.out_max = max_r;
        bus.out_cnt = cnt;
        bus.out_ovf = ovf;
    end
endmodule

// File: tb/tb_frame_sum_max.sv
// Bench for frame_sum_max: default-width instance plus a narrow-sum instance
// sharing the same stimulus, checked by a queue-based scoreboard.
module tb_frame_sum_max;
    localparam int WIDTH = 4;
    localparam int COUNT = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_sum_max_if #(.WIDTH(WIDTH), .SUM_W(7), .CNT_W(CNT_W)) bus7 ();
    frame_sum_max_if #(.WIDTH(WIDTH), .SUM_W(5), .CNT_W(CNT_W)) bus5 ();

    assign bus7.in_valid  = in_valid;
    assign bus7.in_data   = in_data;
    assign bus7.in_last   = in_last;
    assign bus7.out_ready = out_ready;
    assign bus5.in_valid  = in_valid;
    assign bus5.in_data   = in_data;
    assign bus5.in_last   = in_last;
    assign bus5.out_ready = out_ready;

    frame_sum_max #(.WIDTH(WIDTH), .COUNT(COUNT), .SUM_W(7), .CNT_W(CNT_W)) dut7 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus7.slave)
    );
    frame_sum_max #(.WIDTH(WIDTH), .COUNT(COUNT), .SUM_W(5), .CNT_W(CNT_W)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus5.slave)
    );

    typedef struct {
        int unsigned total;
        int unsigned mx;
        int unsigned cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned beats[$];
    bit          m_hold = 1'b0;
    bit          m_live = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the frame as a list of operands and derives results arithmetically.
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_hold = 1'b0;
            m_live = 1'b0;
            beats.delete();
            sb.delete();
        end else begin
            if (clear) begin
                if (m_hold && sb.size() > 0) void'(sb.pop_front());
                m_hold = 1'b0;
                beats.delete();
            end else if (m_hold) begin
                if (out_ready) begin
                    m_hold = 1'b0;
                    beats.delete();
                end
            end else if (m_live && in_valid) begin
                beats.push_back(int'(in_data));
                if (in_last || beats.size() == COUNT) begin
                    exp_t e;
                    e.total = 0;
                    e.mx    = 0;
                    e.cnt   = beats.size();
                    foreach (beats[i]) begin
                        e.total += beats[i];
                        if (beats[i] > e.mx) e.mx = beats[i];
                    end
                    sb.push_back(e);
                    m_hold = 1'b1;
                end
            end
            m_live = 1'b1;
        end
    end

    // Monitor: compares handshake and any presented result against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("in_ready7", int'(bus7.in_ready), int'(m_live && !m_hold));
            chk("in_ready5", int'(bus5.in_ready), int'(m_live && !m_hold));
            chk("out_valid7", int'(bus7.out_valid), int'(m_hold));
            chk("out_valid5", int'(bus5.out_valid), int'(m_hold));
            if (bus7.out_valid || bus5.out_valid) begin
                if (sb.size() == 0) begin
                    chk("result_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb[0];
                    chk("sum7", int'(bus7.out_sum), int'(e.total % 128));
                    chk("ovf7", int'(bus7.out_ovf), int'(e.total >= 128));
                    chk("max7", int'(bus7.out_max), int'(e.mx));
                    chk("cnt7", int'(bus7.out_cnt), int'(e.cnt));
                    chk("sum5", int'(bus5.out_sum), int'(e.total % 32));
                    chk("ovf5", int'(bus5.out_ovf), int'(e.total >= 32));
                    chk("max5", int'(bus5.out_max), int'(e.mx));
                    chk("cnt5", int'(bus5.out_cnt), int'(e.cnt));
                    if (out_ready && !clear && rst_n) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic send(input int d, input bit l);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        in_last  = l;
        t = 0;
        while (!bus7.in_ready) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", int'(bus7.in_ready), 0);
        chk("reset_out_valid", int'(bus7.out_valid), 0);
        chk("reset_out_sum", int'(bus7.out_sum), 0);
        rst_n = 1'b1;

        // Full frame 1..8, also overflows the narrow instance.
        for (int i = 1; i <= 8; i++) send(i, 1'b0);
        idle(2);
        // Short frames.
        send(9, 1'b0); send(3, 1'b0); send(15, 1'b1);
        send(0, 1'b0); send(0, 1'b1);
        idle(2);
        // Backpressure with waiting operand.
        out_ready = 1'b0;
        send(5, 1'b0); send(5, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'd7; in_last = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        send(7, 1'b0); send(7, 1'b1);
        idle(2);
        // Saturating operands: wraps the 5-bit sum, in_last on the 8th beat.
        for (int i = 0; i < 8; i++) send(15, i == 7);
        idle(2);
        // Abort a partial frame.
        send(4, 1'b0); send(4, 1'b0);
        do_clear();
        send(1, 1'b1);
        idle(2);
        // Clear drops a held result.
        out_ready = 1'b0;
        send(6, 1'b1);
        idle(2);
        do_clear();
        out_ready = 1'b1;
        // Gapped input.
        send(2, 1'b0); idle(3); send(6, 1'b0); idle(1); send(1, 1'b1);
        idle(2);
        // Async reset while a result is held.
        out_ready = 1'b0;
        send(3, 1'b1);
        idle(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid7", int'(bus7.out_valid), 0);
        chk("async_rst_out_valid5", int'(bus5.out_valid), 0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = ($urandom_range(0, 3) == 0) ? 4'd15 : WIDTH'($urandom_range(0, 15));
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("drain_scoreboard", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_sum_max.md
Name: frame_sum_max

Overview:
- Sequential front-end that collects a frame of unsigned operands over a valid/ready stream.
- Accumulates the running sum, running maximum and sample count for the frame.
- Presents one result per frame on a held output handshake.
- Feeds the team's adder/compare datapath (ripple/CSA sum, max select) with frame-level totals, replacing per-operand combinational wiring with a streaming stage.

Parameters:
- WIDTH, 4, bit width of each input operand (unsigned).
- COUNT, 8, maximum samples per frame; frame closes automatically on the COUNT-th accepted beat.
- SUM_W, 7, accumulator/result width; WIDTH+ceil(log2(COUNT)) guarantees no overflow at defaults.
- CNT_W, 4, sample counter width; must hold the value COUNT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; discards the partial frame and any held result
- in_valid  input  1  upstream operand valid
- in_ready  output  1  block can accept an operand this cycle
- in_data  input  WIDTH  unsigned operand
- in_last  input  1  qualifies the accepted beat as the final beat of a short frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts the result
- out_sum  output  SUM_W  sum of the frame's operands (modulo 2^SUM_W)
- out_max  output  WIDTH  largest operand in the frame
- out_cnt  output  CNT_W  number of operands in the frame, 1..COUNT
- out_ovf  output  1  sticky: the sum carried out of SUM_W at least once during the frame

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low, asynchronous: state=ACC; accumulator, max, count, ovf, out_valid and all out_* = 0.
  - in_ready rises in the first cycle after rst_n deasserts.
- States and handshake:
  - ACC: in_ready=1, out_valid=0. A beat is accepted when in_valid && in_ready.
  - HOLD: in_ready=0, out_valid=1.
- Per accepted beat in ACC:
  - sum <= sum + zero-extended in_data.
  - ovf |= carry out of bit SUM_W-1.
  - cnt <= cnt+1.
  - max <= in_data on the first beat of a frame (cnt==0), else the larger of max and in_data.
- Frame close:
  - Trigger: an accepted beat with in_last=1, or with cnt+1==COUNT.
  - That beat's contribution is included in the result.
  - Next cycle: state=HOLD; out_sum/out_max/out_cnt/out_ovf show final values; out_valid=1.
  - Latency from final accepted beat to out_valid is exactly 1 cycle.
- In HOLD:
  - out_* stay stable while out_valid && !out_ready.
  - in_data and in_last are ignored.
  - When out_ready=1: next cycle out_valid=0, in_ready=1, and sum/max/cnt/ovf clear to 0.
  - This gives one bubble cycle per frame; there is no same-cycle bypass.
- Outputs outside HOLD: out_* may track internal registers but are only meaningful when out_valid=1. The bench checks them only while valid.
- in_valid=0 in ACC: no state change; cnt holds. Gaps mid-frame are legal.
- in_last on the COUNT-th beat: single close, no double frame.
- clear:
  - Synchronous; takes priority over accept/handshake in the same cycle.
  - Next cycle: state=ACC, registers 0, out_valid=0.
  - A result held in HOLD is dropped without out_ready.
- Async reset mid-frame or mid-HOLD: immediate return to reset values; no partial result emitted.
- Arithmetic: unsigned only. out_sum wraps modulo 2^SUM_W, with out_ovf flagging the wrap. Max comparison is unsigned.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. Both ready/valid outputs are functions of state only.

Test Plan:
- Full frame: 8 beats of in_data = 1,2,3,4,5,6,7,8 back-to-back, out_ready=1 → one cycle after the 8th beat, out_valid=1 with out_sum=36, out_max=8, out_cnt=8, out_ovf=0; then in_ready=1 after one bubble.
- Short frame: beats 9, 3, 15 with in_last on 15 → out_sum=27, out_max=15, out_cnt=3; a following frame of 0, 0 with in_last → out_sum=0, out_max=0, out_cnt=2.
- Backpressure: close a frame of 5, 5 (in_last) and hold out_ready=0 for 4 cycles while in_valid=1 with data 7 → in_ready=0; out_sum=10 stable; the 7s are not consumed until a cycle after out_ready=1.
- Overflow: SUM_W=5, 8 beats of 15 → out_sum=120 mod 32=24, out_ovf=1, out_max=15.
- Clear/reset: accept 4, 4, then clear → next frame 1 (in_last) gives out_sum=1, out_cnt=1. Assert rst_n=0 while out_valid=1 → out_valid=0 immediately, without waiting for a clock edge.
- Gapped input: beats 2, idle 3 cycles, 6, idle, 1 with in_last → out_sum=9, out_max=6, out_cnt=3, latency still 1 cycle after the last beat.
